iq_dispatch_ctrl: RTL and testbench
===================================

Name: iq_dispatch_ctrl

Overview:
- Dispatch/flush controller for the instruction queue.
- Generates `dispatch_no_hazard` from credit counters that shadow ROB, RS and free-list occupancy.
- Generates `fetch_stall` so fetch never overruns the queue.
- Runs a recovery FSM on branch mispredict: flush the IQ, hold dispatch while fetch refills from the redirected PC, then resume.

Parameters:
- ROB_SIZE, 32, ROB entries; reset/flush value of the ROB credit counter.
- RS_SIZE, 16, RS entries; reset/flush value of the RS credit counter.
- FL_SIZE, 32, free physical registers at reset.
- IQ_SIZE, 10, instruction queue depth (matches `IQ_SIZE).
- REFILL_CYCLES, 2, cycles dispatch stays held after a flush.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- fetch_valid  in  1  fetch presents a valid instruction this cycle
- iq_count  in  $clog2(IQ_SIZE)+1  current IQ occupancy (IQ tail)
- head_has_dest  in  1  instruction about to dispatch writes a destination register
- rob_retire  in  1  one ROB entry freed this cycle
- rs_issue  in  1  one RS entry freed this cycle
- fl_release  in  1  one physical register returned to the free list
- branch_incorrect  in  1  mispredict detected at retire
- fl_restore_cnt  in  $clog2(FL_SIZE)+1  free-list count after architectural map restore
- dispatch_no_hazard  out  1  IQ may dispatch this cycle
- iq_flush  out  1  drives IQ branch_incorrect
- fetch_stall  out  1  fetch must hold its PC
- ctrl_state  out  2  FSM state (debug)
- rob_cred  out  $clog2(ROB_SIZE)+1  ROB credits (debug)
- rs_cred  out  $clog2(RS_SIZE)+1  RS credits (debug)
- fl_cred  out  $clog2(FL_SIZE)+1  free-list credits (debug)
- credit_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, active-high): state=RUN, rob_cred=ROB_SIZE, rs_cred=RS_SIZE, fl_cred=FL_SIZE, refill counter=0, credit_err=0.
  - Outputs during reset: iq_flush=0, dispatch_no_hazard=0, fetch_stall=0.
- FSM states: RUN=0, FLUSH=1, REFILL=2. Encoding 3 is unused and returns to RUN.
  - RUN -> FLUSH when branch_incorrect.
  - FLUSH -> REFILL unconditionally after 1 cycle; load refill counter with REFILL_CYCLES-1.
  - REFILL: decrement counter each cycle; -> RUN when counter==0 and no branch_incorrect.
  - branch_incorrect in any state -> FLUSH. Highest priority; restarts recovery.
- iq_flush = (state==FLUSH). Combinational from the state register: asserted exactly one cycle per flush entry.
- dispatch_no_hazard (combinational) = state==RUN & (iq_count!=0 | fetch_valid) & rob_cred!=0 & rs_cred!=0 & (!head_has_dest | fl_cred!=0) & !branch_incorrect.
  - The fetch_valid term covers the IQ bypass when the queue is empty.
- fetch_stall (combinational) = state==FLUSH | (iq_count>=IQ_SIZE-1 & !dispatch_no_hazard).
  - fetch_stall=0 in REFILL, so the redirected stream fills the IQ.
- Credit update (registered), d = dispatch_no_hazard:
  - rob_cred += rob_retire - d
  - rs_cred += rs_issue - d
  - fl_cred += fl_release - (d & head_has_dest)
  - Simultaneous free and consume on the same counter: net 0.
- Flush reload: on the cycle branch_incorrect is sampled, rob_cred<=ROB_SIZE, rs_cred<=RS_SIZE, fl_cred<=fl_restore_cnt. This overrides same-cycle release pulses.
- Saturation: an increment at max or a decrement at 0 leaves the counter unchanged and sets credit_err. credit_err clears only on reset.

Decomposition:
- Shared package (sys_defs): ROB_SIZE, RS_SIZE, FL_SIZE, IQ_SIZE, and the enum IQ_CTRL_STATE {RUN, FLUSH, REFILL}.
- One sub-module is natural: credit_counter (parameters MAX and WIDTH; inputs inc, dec, load, load_val; outputs count, err), instantiated three times.

Test Plan:
- Reset then idle -> rob_cred=32, rs_cred=16, fl_cred=32, dispatch_no_hazard=0, fetch_stall=0.
- iq_count=0, fetch_valid=1, head_has_dest=1, no releases, for 16 cycles -> dispatch_no_hazard=1 for 16 cycles.
  - Then rs_cred=0 and dispatch_no_hazard=0.
  - Next: rs_issue=1 for one cycle -> one dispatch, after which rs_cred returns to 0.
- iq_count=9, all credits 0, fetch_valid=1 -> fetch_stall=1.
  - Raise rob_retire, rs_issue and fl_release for one cycle -> dispatch_no_hazard=1 and fetch_stall=0 in the following cycle.
- branch_incorrect pulse with fl_restore_cnt=20:
  - next cycle iq_flush=1, fetch_stall=1, credits 32/16/20;
  - then 2 REFILL cycles with dispatch_no_hazard=0 and fetch_stall=0;
  - then RUN.
- branch_incorrect on the 1st REFILL cycle -> FLUSH re-entered, iq_flush=1 again, full 2-cycle REFILL repeated.
- rob_retire=1 while rob_cred=32 -> rob_cred stays 32, credit_err=1 sticky until reset.
  - Reset asserted mid-REFILL -> state=RUN immediately, no clock needed.

Source files
------------

// File: rtl/sys_defs.sv
// Shared definitions for the dispatch/flush controller slice.
// Holds the structure sizes, derived counter widths and the recovery FSM encoding.
package sys_defs;

   localparam int unsigned ROB_SIZE      = 32;
   localparam int unsigned RS_SIZE       = 16;
   localparam int unsigned FL_SIZE       = 32;
   localparam int unsigned IQ_SIZE       = 10;
   localparam int unsigned REFILL_CYCLES = 2;

   localparam int unsigned ROB_CW = $clog2(ROB_SIZE) + 1;
   localparam int unsigned RS_CW  = $clog2(RS_SIZE) + 1;
   localparam int unsigned FL_CW  = $clog2(FL_SIZE) + 1;
   localparam int unsigned IQ_CW  = $clog2(IQ_SIZE) + 1;
   localparam int unsigned RF_CW  = $clog2(REFILL_CYCLES) + 1;

   // Encoding 2'd3 is unused; the FSM falls back to RUN if it ever appears.
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      REFILL = 2'd2
   } IQ_CTRL_STATE;

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down credit counter with a parallel load and a sticky error flag.
// Ports:
//   clock, reset      - clock, asynchronous active-high reset (count resets to MAX)
//   inc, dec          - free / consume one credit; both together cancel out
//   load, load_val    - overwrite the count (wins over inc/dec)
//   count             - current credit count
//   err               - sticky: set on increment at MAX or decrement at 0
module credit_counter #(
   parameter int unsigned MAX   = 32,
   parameter int unsigned WIDTH = $clog2(MAX) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             err
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             err_q, err_d;

   always_comb begin
      count_d = count_q;
      err_d   = err_q;
      if (load) begin
         count_d = load_val;
      end else if (inc && !dec) begin
         if (count_q == WIDTH'(MAX)) err_d = 1'b1;
         else                        count_d = count_q + 1'b1;
      end else if (dec && !inc) begin
         if (count_q == '0) err_d = 1'b1;
         else               count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= WIDTH'(MAX);
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign count = count_q;
   assign err   = err_q;

endmodule

// File: rtl/iq_dispatch_ctrl.sv
// Instruction-queue dispatch/flush controller.
// Gates dispatch on ROB/RS/free-list credits, stalls fetch before the IQ overruns, and
// sequences mispredict recovery: RUN -> FLUSH (1 cycle) -> REFILL (REFILL_CYCLES) -> RUN.
// Ports:
//   clock, reset                 - clock, asynchronous active-high reset
//   fetch_valid, iq_count        - fetch handshake and current IQ occupancy
//   head_has_dest                - head instruction needs a physical register
//   rob_retire, rs_issue,
//   fl_release                   - one-credit release pulses
//   branch_incorrect,
//   fl_restore_cnt               - mispredict and free-list count after map restore
//   dispatch_no_hazard, iq_flush,
//   fetch_stall                  - control outputs
//   ctrl_state, rob_cred, rs_cred,
//   fl_cred, credit_err          - debug visibility and sticky credit error
module iq_dispatch_ctrl
   import sys_defs::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              fetch_valid,
   input  logic [IQ_CW-1:0]  iq_count,
   input  logic              head_has_dest,
   input  logic              rob_retire,
   input  logic              rs_issue,
   input  logic              fl_release,
   input  logic              branch_incorrect,
   input  logic [FL_CW-1:0]  fl_restore_cnt,
   output logic              dispatch_no_hazard,
   output logic              iq_flush,
   output logic              fetch_stall,
   output logic [1:0]        ctrl_state,
   output logic [ROB_CW-1:0] rob_cred,
   output logic [RS_CW-1:0]  rs_cred,
   output logic [FL_CW-1:0]  fl_cred,
   output logic              credit_err
);

   IQ_CTRL_STATE     state_q, state_d;
   logic [RF_CW-1:0] refill_q, refill_d;
   logic             rob_err, rs_err, fl_err;

   // Recovery FSM; a mispredict restarts recovery from any state.
   always_comb begin
      state_d  = state_q;
      refill_d = refill_q;
      if (branch_incorrect) begin
         state_d = FLUSH;
      end else begin
         case (state_q)
            RUN:    state_d = RUN;
            FLUSH: begin
               state_d  = REFILL;
               refill_d = RF_CW'(REFILL_CYCLES - 1);
            end
            REFILL: begin
               if (refill_q == '0) state_d = RUN;
               else                refill_d = refill_q - 1'b1;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= RUN;
         refill_q <= '0;
      end else begin
         state_q  <= state_d;
         refill_q <= refill_d;
      end
   end

   // fetch_valid covers the empty-queue bypass. Reset gating keeps outputs quiet while
   // the state register sits in RUN during reset.
   assign dispatch_no_hazard = !reset && (state_q == RUN) &&
                               ((iq_count != '0) || fetch_valid) &&
                               (rob_cred != '0) && (rs_cred != '0) &&
                               (!head_has_dest || (fl_cred != '0)) &&
                               !branch_incorrect;

   assign iq_flush    = (state_q == FLUSH);
   assign fetch_stall = !reset && ((state_q == FLUSH) ||
                        ((iq_count >= IQ_CW'(IQ_SIZE - 1)) && !dispatch_no_hazard));
   assign ctrl_state  = state_q;

   credit_counter #(.MAX(ROB_SIZE), .WIDTH(ROB_CW)) u_rob_cred (
      .clock    (clock),
      .reset    (reset),
      .inc      (rob_retire),
      .dec      (dispatch_no_hazard),
      .load     (branch_incorrect),
      .load_val (ROB_CW'(ROB_SIZE)),
      .count    (rob_cred),
      .err      (rob_err)
   );

   credit_counter #(.MAX(RS_SIZE), .WIDTH(RS_CW)) u_rs_cred (
      .clock    (clock),
      .reset    (reset),
      .inc      (rs_issue),
      .dec      (dispatch_no_hazard),
      .load     (branch_incorrect),
      .load_val (RS_CW'(RS_SIZE)),
      .count    (rs_cred),
      .err      (rs_err)
   );

   credit_counter #(.MAX(FL_SIZE), .WIDTH(FL_CW)) u_fl_cred (
      .clock    (clock),
      .reset    (reset),
      .inc      (fl_release),
      .dec      (dispatch_no_hazard && head_has_dest),
      .load     (branch_incorrect),
      .load_val (fl_restore_cnt),
      .count    (fl_cred),
      .err      (fl_err)
   );

   assign credit_err = rob_err | rs_err | fl_err;

endmodule

// File: tb/tb_iq_dispatch_ctrl.sv
// Self-checking bench for iq_dispatch_ctrl: directed recovery/credit scenarios followed by
// randomized traffic, all compared against a behavioural model kept in this module.
module tb_iq_dispatch_ctrl;
   import sys_defs::*;

   logic              clock = 1'b0;
   logic              reset;
   logic              fetch_valid;
   logic [IQ_CW-1:0]  iq_count;
   logic              head_has_dest;
   logic              rob_retire;
   logic              rs_issue;
   logic              fl_release;
   logic              branch_incorrect;
   logic [FL_CW-1:0]  fl_restore_cnt;
   logic              dispatch_no_hazard;
   logic              iq_flush;
   logic              fetch_stall;
   logic [1:0]        ctrl_state;
   logic [ROB_CW-1:0] rob_cred;
   logic [RS_CW-1:0]  rs_cred;
   logic [FL_CW-1:0]  fl_cred;
   logic              credit_err;

   iq_dispatch_ctrl dut (
      .clock              (clock),
      .reset              (reset),
      .fetch_valid        (fetch_valid),
      .iq_count           (iq_count),
      .head_has_dest      (head_has_dest),
      .rob_retire         (rob_retire),
      .rs_issue           (rs_issue),
      .fl_release         (fl_release),
      .branch_incorrect   (branch_incorrect),
      .fl_restore_cnt     (fl_restore_cnt),
      .dispatch_no_hazard (dispatch_no_hazard),
      .iq_flush           (iq_flush),
      .fetch_stall        (fetch_stall),
      .ctrl_state         (ctrl_state),
      .rob_cred           (rob_cred),
      .rs_cred            (rs_cred),
      .fl_cred            (fl_cred),
      .credit_err         (credit_err)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Behavioural model: mode 0=running, 1=flushing, 2=refilling with m_left cycles to go.
   int m_rob, m_rs, m_fl, m_mode, m_left;
   bit m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_rob = ROB_SIZE; m_rs = RS_SIZE; m_fl = FL_SIZE;
      m_mode = 0; m_left = 0; m_err = 1'b0;
   endtask

   function automatic bit m_disp();
      return (m_mode == 0) && ((iq_count != 0) || fetch_valid) && (m_rob > 0) && (m_rs > 0) &&
             (!head_has_dest || (m_fl > 0)) && !branch_incorrect;
   endfunction

   function automatic bit m_stall();
      return (m_mode == 1) || ((int'(iq_count) >= int'(IQ_SIZE) - 1) && !m_disp());
   endfunction

   task automatic upd(inout int v, input int delta, input int mx);
      if (v + delta > mx || v + delta < 0) m_err = 1'b1;
      else v = v + delta;
   endtask

   task automatic model_clock();
      bit d;
      d = m_disp();
      if (branch_incorrect) begin
         m_rob = ROB_SIZE; m_rs = RS_SIZE; m_fl = int'(fl_restore_cnt); m_mode = 1;
      end else begin
         upd(m_rob, int'(rob_retire) - int'(d), ROB_SIZE);
         upd(m_rs, int'(rs_issue) - int'(d), RS_SIZE);
         upd(m_fl, int'(fl_release) - int'(d && head_has_dest), FL_SIZE);
         if (m_mode == 1) begin
            m_mode = 2; m_left = REFILL_CYCLES;
         end else if (m_mode == 2) begin
            m_left--;
            if (m_left == 0) m_mode = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("dispatch_no_hazard", dispatch_no_hazard, m_disp());
      chk("fetch_stall", fetch_stall, m_stall());
      chk("iq_flush", iq_flush, m_mode == 1);
      chk("ctrl_state", ctrl_state, m_mode);
      chk("rob_cred", rob_cred, m_rob);
      chk("rs_cred", rs_cred, m_rs);
      chk("fl_cred", fl_cred, m_fl);
      chk("credit_err", credit_err, m_err);
   endtask

   // Inputs change at posedge+1; checks land mid-cycle, the model advances at the edge.
   task automatic step();
      #3;
      check_all();
      @(posedge clock);
      model_clock();
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic drive(input bit fv, input int iq, input bit hd, input bit ret, input bit iss,
                        input bit rel, input bit bi, input int rest);
      fetch_valid = fv; iq_count = IQ_CW'(iq); head_has_dest = hd; rob_retire = ret;
      rs_issue = iss; fl_release = rel; branch_incorrect = bi; fl_restore_cnt = FL_CW'(rest);
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #3;
      chk("reset_rob", rob_cred, ROB_SIZE);
      chk("reset_rs", rs_cred, RS_SIZE);
      chk("reset_fl", fl_cred, FL_SIZE);
      chk("reset_state", ctrl_state, 0);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;

      // Idle after reset.
      step();
      step();

      // Dispatch via bypass until RS credits run out.
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) begin
         settle();
         chk("burst_dispatch", dispatch_no_hazard, 1);
         step();
      end
      settle();
      chk("rs_empty_cred", rs_cred, 0);
      chk("rs_empty_block", dispatch_no_hazard, 0);
      step();
      drive(1, 0, 1, 0, 1, 0, 0, 0);
      step();
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      settle();
      chk("rs_one_dispatch", dispatch_no_hazard, 1);
      step();
      settle();
      chk("rs_back_to_zero", rs_cred, 0);

      // Drain ROB and free list to zero as well.
      drive(1, 0, 1, 0, 1, 0, 0, 0);
      for (int i = 0; i < 16; i++) step();
      drive(1, 0, 0, 1, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      step();
      settle();
      chk("drain_rob", rob_cred, 0);
      chk("drain_rs", rs_cred, 0);
      chk("drain_fl", fl_cred, 0);

      // Nearly-full IQ with no credits stalls fetch; one release of each frees it.
      drive(1, 9, 1, 0, 0, 0, 0, 0);
      settle();
      chk("full_stall", fetch_stall, 1);
      step();
      drive(1, 9, 1, 1, 1, 1, 0, 0);
      step();
      drive(1, 9, 1, 0, 0, 0, 0, 0);
      settle();
      chk("release_dispatch", dispatch_no_hazard, 1);
      chk("release_nostall", fetch_stall, 0);
      step();

      // Mispredict with free-list restore of 20.
      drive(1, 0, 0, 1, 1, 1, 1, 20);
      step();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      chk("flush_iq_flush", iq_flush, 1);
      chk("flush_stall", fetch_stall, 1);
      chk("flush_rob", rob_cred, 32);
      chk("flush_rs", rs_cred, 16);
      chk("flush_fl", fl_cred, 20);
      step();
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("refill_state", ctrl_state, 2);
         chk("refill_hold", dispatch_no_hazard, 0);
         chk("refill_nostall", fetch_stall, 0);
         step();
      end
      settle();
      chk("resume_run", ctrl_state, 0);
      chk("resume_dispatch", dispatch_no_hazard, 1);
      step();

      // Mispredict again on the first REFILL cycle restarts recovery.
      drive(1, 0, 0, 0, 0, 0, 1, 25);
      step();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 0, 0, 0, 1, 24);
      step();
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      settle();
      chk("reflush_iq_flush", iq_flush, 1);
      chk("reflush_fl", fl_cred, 24);
      step();
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("rerefill_state", ctrl_state, 2);
         step();
      end
      settle();
      chk("reresume_run", ctrl_state, 0);
      step();

      // Overflow sets the sticky error.
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      step();
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      settle();
      chk("overflow_rob", rob_cred, 32);
      chk("overflow_err", credit_err, 1);
      step();

      // Asynchronous reset in the middle of REFILL.
      drive(1, 0, 1, 0, 0, 0, 1, 10);
      step();
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      step();
      step();
      reset = 1'b1;
      #1;
      chk("async_state", ctrl_state, 0);
      chk("async_err", credit_err, 0);
      chk("async_fl", fl_cred, FL_SIZE);
      chk("async_dispatch", dispatch_no_hazard, 0);
      chk("async_stall", fetch_stall, 0);
      chk("async_flush", iq_flush, 0);
      model_reset();
      @(posedge clock); #1;
      reset = 1'b0;
      step();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 1), $urandom_range(0, IQ_SIZE), $urandom_range(0, 1),
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 19) == 0, $urandom_range(0, FL_SIZE));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
